// File: rtl/vga_timing_gen.sv
// Video timing generator: free-running H/V raster counters with sync,
// blanking, scaled window coordinates, vblank pulse and frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV   = 1,
    parameter int H_VISIBLE = 320,
    parameter int H_FRONT   = 8,
    parameter int H_SYNC    = 48,
    parameter int H_BACK    = 24,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int WIN_W     = 256,
    parameter int WIN_H     = 240,
    parameter int X_SHIFT   = 0,
    parameter int Y_SHIFT   = 1,
    parameter int WIN_X0    = 32,
    parameter int WIN_Y0    = 0
) (
    input  logic       clk_12_5875,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       in_window,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       vblank_start,
    output logic       pix_step,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS0 = H_VISIBLE + H_FRONT;
    localparam int VS0 = V_VISIBLE + V_FRONT;
    localparam int WIN_XW = WIN_W << X_SHIFT;
    localparam int WIN_YH = WIN_H << Y_SHIFT;
    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((WIN_X0 + WIN_XW > H_VISIBLE) ||
        (WIN_Y0 + WIN_YH > V_VISIBLE)) begin : g_bad_window
        $error("vga_timing_gen: window exceeds visible area");
    end

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [7:0]    r_frame;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_visible;
    logic          r_in_window;
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic          r_vblank;
    logic          r_pix_step;

    logic [DW-1:0] w_div_n;
    logic [HW-1:0] w_h_n;
    logic [VW-1:0] w_v_n;
    logic          w_step;
    logic          w_hwrap;
    logic          w_vwrap;
    logic          w_vb;
    logic [31:0]   w_h32;
    logic [31:0]   w_v32;
    logic [31:0]   w_hx;
    logic [31:0]   w_vy;
    logic          w_win;

    always_comb begin
        w_step  = (32'(r_div) == CLK_DIV - 1);
        w_hwrap = w_step && (32'(r_hcount) == H_TOTAL - 1);
        w_vwrap = w_hwrap && (32'(r_vcount) == V_TOTAL - 1);
        w_div_n = w_step ? '0 : r_div + DW'(1);
        w_h_n   = r_hcount;
        w_v_n   = r_vcount;
        if (w_step) w_h_n = w_hwrap ? '0 : r_hcount + HW'(1);
        if (w_hwrap) w_v_n = w_vwrap ? '0 : r_vcount + VW'(1);
        w_vb = w_hwrap && (32'(r_vcount) == V_VISIBLE - 1);
        // Reset overrides any advance, wrap or vblank entry this edge
        if (rst) begin
            w_div_n = '0;
            w_h_n   = '0;
            w_v_n   = '0;
            w_vb    = 1'b0;
        end
    end

    // Decode of the next position; offsets wrap so one compare bounds both sides
    always_comb begin
        w_h32 = 32'(w_h_n);
        w_v32 = 32'(w_v_n);
        w_hx  = w_h32 - 32'(WIN_X0);
        w_vy  = w_v32 - 32'(WIN_Y0);
        w_win = (w_hx < 32'(WIN_XW)) && (w_vy < 32'(WIN_YH));
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            r_div    <= '0;
            r_hcount <= '0;
            r_vcount <= '0;
            r_frame  <= '0;
        end else begin
            r_div    <= w_div_n;
            r_hcount <= w_h_n;
            r_vcount <= w_v_n;
            if (w_vb) r_frame <= r_frame + 8'd1;
        end
    end

    always_ff @(posedge clk_12_5875) begin
        r_hsync     <= ((w_h32 - 32'(HS0)) < 32'(H_SYNC)) == HS_ACT;
        r_vsync     <= ((w_v32 - 32'(VS0)) < 32'(V_SYNC)) == VS_ACT;
        r_visible   <= (w_h32 < 32'(H_VISIBLE)) && (w_v32 < 32'(V_VISIBLE));
        r_in_window <= w_win;
        r_x         <= w_win ? 8'(w_hx >> X_SHIFT) : 8'd0;
        r_y         <= w_win ? 8'(w_vy >> Y_SHIFT) : 8'd0;
        r_vblank    <= w_vb;
        r_pix_step  <= (32'(w_div_n) == CLK_DIV - 1);
    end

    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign visible      = r_visible;
    assign in_window    = r_in_window;
    assign x            = r_x;
    assign y            = r_y;
    assign vblank_start = r_vblank;
    assign pix_step     = r_pix_step;
    assign frame_count  = r_frame;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three configurations driven with random resets and
// checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic       win;
        logic [7:0] x;
        logic [7:0] y;
        logic       vb;
        logic       ps;
        logic [7:0] fc;
    } obs_t;

    typedef struct packed {
        int cd; int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
        int hp; int vp; int ww; int wh;
        int xs; int ys; int x0; int y0;
    } cfg_t;

    typedef struct packed {
        int   t;
        obs_t o0;
        obs_t o1;
        obs_t o2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obs_t a0, a1, a2;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    cfg_t c0, c1, c2;

    vga_timing_gen u0 (
        .clk_12_5875(clk), .rst(rst),
        .hsync(a0.hs), .vsync(a0.vs), .visible(a0.vis),
        .in_window(a0.win), .x(a0.x), .y(a0.y),
        .vblank_start(a0.vb), .pix_step(a0.ps), .frame_count(a0.fc)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .HSYNC_POL(1), .VSYNC_POL(1), .WIN_W(8), .WIN_H(5),
        .X_SHIFT(1), .Y_SHIFT(1), .WIN_X0(2), .WIN_Y0(1)
    ) u1 (
        .clk_12_5875(clk), .rst(rst),
        .hsync(a1.hs), .vsync(a1.vs), .visible(a1.vis),
        .in_window(a1.win), .x(a1.x), .y(a1.y),
        .vblank_start(a1.vb), .pix_step(a1.ps), .frame_count(a1.fc)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .WIN_W(2), .WIN_H(3),
        .X_SHIFT(1), .Y_SHIFT(0), .WIN_X0(0), .WIN_Y0(0)
    ) u2 (
        .clk_12_5875(clk), .rst(rst),
        .hsync(a2.hs), .vsync(a2.vs), .visible(a2.vis),
        .in_window(a2.win), .x(a2.x), .y(a2.y),
        .vblank_start(a2.vb), .pix_step(a2.ps), .frame_count(a2.fc)
    );

    // Position derived from clocks elapsed since reset
    function automatic obs_t model(cfg_t c, int t);
        obs_t o;
        int ht, vt, p, h, l, v;
        bit w;
        ht = c.hv + c.hf + c.hsw + c.hb;
        vt = c.vv + c.vf + c.vsw + c.vb;
        p  = t / c.cd;
        h  = p % ht;
        l  = p / ht;
        v  = l % vt;
        w  = (h >= c.x0) && (h < c.x0 + (c.ww << c.xs)) &&
             (v >= c.y0) && (v < c.y0 + (c.wh << c.ys));
        o.hs  = ((h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hsw)) == (c.hp != 0);
        o.vs  = ((v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vsw)) == (c.vp != 0);
        o.vis = (h < c.hv) && (v < c.vv);
        o.win = w;
        o.x   = w ? 8'((h - c.x0) >> c.xs) : 8'd0;
        o.y   = w ? 8'((v - c.y0) >> c.ys) : 8'd0;
        o.vb  = (h == 0) && (v == c.vv) && (t % c.cd == 0);
        o.ps  = (t % c.cd) == c.cd - 1;
        o.fc  = (l >= c.vv) ? 8'(((l - c.vv) / vt + 1) % 256) : 8'd0;
        return o;
    endfunction

    task automatic step(input bit r, inout int t);
        exp_t e;
        rst = r;
        t = r ? 0 : t + 1;
        e.t  = t;
        e.o0 = model(c0, t);
        e.o1 = model(c1, t);
        e.o2 = model(c2, t);
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 3;
                if (a0 !== e.o0) begin
                    errors++;
                    $display("FAIL u0 t=%0d got=%h exp=%h", e.t, a0, e.o0);
                end
                if (a1 !== e.o1) begin
                    errors++;
                    $display("FAIL u1 t=%0d got=%h exp=%h", e.t, a1, e.o1);
                end
                if (a2 !== e.o2) begin
                    errors++;
                    $display("FAIL u2 t=%0d got=%h exp=%h", e.t, a2, e.o2);
                end
            end
        end
    end

    initial begin
        int t = 0;
        c0 = '{1, 320, 8, 48, 24, 480, 10, 2, 33, 0, 0, 256, 240, 0, 1, 32, 0};
        c1 = '{2, 20, 2, 3, 5, 12, 2, 2, 2, 1, 1, 8, 5, 1, 1, 2, 1};
        c2 = '{1, 4, 1, 1, 2, 3, 1, 1, 1, 0, 0, 2, 3, 1, 0, 0, 0};
        step(1'b1, t);
        step(1'b1, t);
        for (int i = 0; i < 6000; i++)
            step($urandom_range(0, 499) == 0, t);
        // Reset on the edge that would otherwise enter vblank on u2
        step(1'b1, t);
        while (t != 23) step(1'b0, t);
        step(1'b1, t);
        for (int i = 0; i < 14000; i++)
            step(1'b0, t);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
